axis_burst_master: RTL

- AXI-Stream initiator that drives the coprocessor's slave stream and captures its master-stream results.
- Control logic preloads a TX buffer, pulses START, and the block transmits a TLAST-terminated burst.
- The block then collects a fixed number of result words into an RX buffer, readable by address.
- Used as the on-chip stimulus/capture companion to the stream coprocessor IP.

---
 rtl/axis_burst_pkg.sv | 23 ++
 rtl/axis_burst_ram.sv | 43 ++++
 rtl/axis_burst_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/axis_burst_pkg.sv
// ============================================================================
// Module      : axis_burst_pkg
// Description : Shared FSM state type and default sizes for the burst master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_burst_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TX_DEPTH   = 16;
    localparam int DEF_RX_DEPTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/axis_burst_ram.sv
// ============================================================================
// Module      : axis_burst_ram
// Description : Simple dual-port RAM, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_burst_ram
    import axis_burst_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_TX_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Storage itself is never reset; only the output register is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= r_mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_burst_master.sv
// ============================================================================
// Module      : axis_burst_master
// Description : AXI-Stream burst initiator with TX preload and RX capture
//               buffers. Optional macro RX_TLAST_CHECK_EN adds RX_TLAST_ERR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_burst_master
    import axis_burst_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TX_DEPTH   = DEF_TX_DEPTH,
    parameter int RX_DEPTH   = DEF_RX_DEPTH
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          LOAD_VALID,
    input  logic [DATA_WIDTH-1:0]         LOAD_DATA,
    output logic                          LOAD_READY,
    input  logic                          START,
    input  logic [$clog2(TX_DEPTH+1)-1:0] TX_LEN,
    input  logic [$clog2(RX_DEPTH+1)-1:0] RX_LEN,
    input  logic                          CLEAR,
    output logic                          START_ERR,
    output logic                          BUSY,
    output logic                          DONE,
    input  logic [$clog2(RX_DEPTH)-1:0]   RD_ADDR,
    output logic [DATA_WIDTH-1:0]         RD_DATA,
    output logic                          M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic                          M_AXIS_TLAST,
    input  logic                          M_AXIS_TREADY,
    input  logic                          S_AXIS_TVALID,
    input  logic [DATA_WIDTH-1:0]         S_AXIS_TDATA,
    input  logic                          S_AXIS_TLAST,
    output logic                          S_AXIS_TREADY
`ifdef RX_TLAST_CHECK_EN
    ,
    output logic                          RX_TLAST_ERR
`endif
);

    localparam int C_TX_LW = $clog2(TX_DEPTH + 1);
    localparam int C_TX_AW = $clog2(TX_DEPTH);
    localparam int C_RX_LW = $clog2(RX_DEPTH + 1);
    localparam int C_RX_AW = $clog2(RX_DEPTH);

    state_t               r_state;
    state_t               w_state_next;
    logic [C_TX_LW-1:0]   r_tx_count;
    logic [C_TX_LW-1:0]   r_tx_len;
    logic [C_TX_LW-1:0]   r_tx_idx;
    logic [C_TX_LW-1:0]   w_tx_idx_next;
    logic [C_RX_LW-1:0]   r_rx_len;
    logic [C_RX_LW-1:0]   r_rx_idx;
    logic                 r_start_err;
    logic [DATA_WIDTH-1:0] w_tx_rdata;

    logic w_can_start;
    logic w_clear;
    logic w_start_bad;
    logic w_start_ok;
    logic w_start_rej;
    logic w_load_fire;
    logic w_tx_hs;
    logic w_tx_last;
    logic w_rx_hs;
    logic w_rx_last;

    // START and CLEAR are honoured only when no transfer is in flight.
    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_clear     = CLEAR && w_can_start;
    assign w_start_bad = (TX_LEN == '0) || (TX_LEN > r_tx_count) ||
                         (RX_LEN > C_RX_LW'(RX_DEPTH));
    assign w_start_ok  = START && w_can_start && !w_clear && !w_start_bad;
    assign w_start_rej = START && w_can_start && !w_clear && w_start_bad;

    assign w_load_fire = LOAD_VALID && LOAD_READY && !CLEAR;
    assign w_tx_hs     = M_AXIS_TVALID && M_AXIS_TREADY;
    assign w_tx_last   = (r_tx_idx == r_tx_len - C_TX_LW'(1));
    assign w_rx_hs     = S_AXIS_TVALID && S_AXIS_TREADY;
    assign w_rx_last   = (r_rx_idx == r_rx_len - C_RX_LW'(1));

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_clear) begin
                    w_state_next = ST_IDLE;
                end else if (w_start_ok) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_tx_hs && w_tx_last) begin
                    w_state_next = (r_rx_len == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_rx_hs && w_rx_last) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        LOAD_READY    = 1'b0;
        BUSY          = 1'b0;
        DONE          = 1'b0;
        M_AXIS_TVALID = 1'b0;
        S_AXIS_TREADY = 1'b0;
        case (r_state)
            ST_IDLE: LOAD_READY = (r_tx_count < C_TX_LW'(TX_DEPTH));
            ST_SEND: begin
                BUSY          = 1'b1;
                M_AXIS_TVALID = 1'b1;
            end
            ST_RECV: begin
                BUSY          = 1'b1;
                S_AXIS_TREADY = 1'b1;
            end
            ST_DONE: DONE = 1'b1;
            default: ;
        endcase
    end

    // The TX RAM is addressed with the upcoming index so its registered
    // output always shows buf[tx_idx], including the first beat after START.
    always_comb begin
        w_tx_idx_next = r_tx_idx;
        if (r_state != ST_SEND) begin
            w_tx_idx_next = '0;
        end else if (w_tx_hs) begin
            w_tx_idx_next = r_tx_idx + C_TX_LW'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_tx_count  <= '0;
            r_tx_len    <= '0;
            r_tx_idx    <= '0;
            r_rx_len    <= '0;
            r_rx_idx    <= '0;
            r_start_err <= 1'b0;
        end else begin
            r_tx_idx    <= w_tx_idx_next;
            r_start_err <= w_start_rej;
            if (w_clear) begin
                r_tx_count <= '0;
                r_rx_idx   <= '0;
            end else begin
                if (w_load_fire) begin
                    r_tx_count <= r_tx_count + C_TX_LW'(1);
                end
                if (w_start_ok) begin
                    r_tx_len <= TX_LEN;
                    r_rx_len <= RX_LEN;
                    r_rx_idx <= '0;
                end else if (w_rx_hs) begin
                    r_rx_idx <= r_rx_idx + C_RX_LW'(1);
                end
            end
        end
    end

    assign START_ERR    = r_start_err;
    assign M_AXIS_TLAST = M_AXIS_TVALID && w_tx_last;
    assign M_AXIS_TDATA = M_AXIS_TVALID ? w_tx_rdata : '0;

    axis_burst_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_ram (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .we    (w_load_fire),
        .waddr (r_tx_count[C_TX_AW-1:0]),
        .wdata (LOAD_DATA),
        .raddr (w_tx_idx_next[C_TX_AW-1:0]),
        .rdata (w_tx_rdata)
    );

    axis_burst_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_ram (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .we    (w_rx_hs),
        .waddr (r_rx_idx[C_RX_AW-1:0]),
        .wdata (S_AXIS_TDATA),
        .raddr (RD_ADDR),
        .rdata (RD_DATA)
    );

`ifdef RX_TLAST_CHECK_EN
    logic r_tlast_err;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_tlast_err <= 1'b0;
        end else if (w_clear) begin
            r_tlast_err <= 1'b0;
        end else if (w_rx_hs && (S_AXIS_TLAST != w_rx_last)) begin
            r_tlast_err <= 1'b1;
        end
    end

    assign RX_TLAST_ERR = r_tlast_err;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = S_AXIS_TLAST;
`endif

endmodule

`default_nettype wire
